// File: rtl/ika9958_tilecyc_gen_pkg.sv
// Shared mnemonics for the tile-cycle generator: decode-mode encoding and
// default load/wrap/window constants.
package IKA9958_mnemonics;

   typedef enum logic [1:0] {
      DM_ANY   = 2'b00,
      DM_TXT   = 2'b01,
      DM_GFX   = 2'b10,
      DM_NEVER = 2'b11
   } dec_mode_t;

   localparam logic [8:0] DEF_SYNC_LD  = 9'h1E3;
   localparam logic [8:0] DEF_WRAP_TXT = 9'h177;
   localparam logic [8:0] DEF_WRAP_GFX = 9'h12F;
   localparam logic [8:0] DEF_WRAP_LD  = 9'h1D1;
   localparam logic [8:0] DEF_WIN_ON   = 9'h000;
   localparam logic [8:0] DEF_WIN_OFF  = 9'h140;

endpackage

// File: rtl/ika9958_tilecyc_gen_dec.sv
// One programmable decode-table entry: mode gate plus full-count or
// pixel-field-only compare against the current count.
module ika9958_tilecyc_dec
   import IKA9958_mnemonics::*;
#(
   parameter int unsigned LO_W = 4,
   parameter int unsigned CW   = 9
)(
   input  logic [CW-1:0] i_cnt,
   input  logic [CW-1:0] i_val,
   input  logic          i_lo_only,
   input  logic [1:0]    i_mode,
   input  logic          i_txt,
   output logic          o_hit
);

   dec_mode_t w_mode;
   logic      w_mode_ok;
   logic      w_eq;

   assign w_mode = dec_mode_t'(i_mode);

   always_comb begin
      w_mode_ok = 1'b0;
      case (w_mode)
         DM_ANY:   w_mode_ok = 1'b1;
         DM_TXT:   w_mode_ok = i_txt;
         DM_GFX:   w_mode_ok = ~i_txt;
         DM_NEVER: w_mode_ok = 1'b0;
         default:  w_mode_ok = 1'b0;
      endcase
   end

   assign w_eq  = i_lo_only ? (i_cnt[LO_W-1:0] == i_val[LO_W-1:0]) : (i_cnt == i_val);
   assign o_hit = w_mode_ok & w_eq;

endmodule

// File: rtl/ika9958_tilecyc_gen.sv
// Horizontal tile/pixel cycle counter with active-window flag and NDEC-entry
// decode table. Define IKA9958_TILECYC_DECREG_EN to register the decode outputs.
module ika9958_tilecyc_gen
   import IKA9958_mnemonics::*;
#(
   parameter int unsigned LO_W   = 4,
   parameter int unsigned HI_W   = 5,
   parameter int unsigned TXT_PX = 12,
   parameter int unsigned GFX_PX = 16,
   parameter int unsigned NDEC   = 8,
   parameter logic [HI_W+LO_W-1:0] SYNC_LD  = DEF_SYNC_LD,
   parameter logic [HI_W+LO_W-1:0] WRAP_TXT = DEF_WRAP_TXT,
   parameter logic [HI_W+LO_W-1:0] WRAP_GFX = DEF_WRAP_GFX,
   parameter logic [HI_W+LO_W-1:0] WRAP_LD  = DEF_WRAP_LD,
   parameter logic [HI_W+LO_W-1:0] WIN_ON   = DEF_WIN_ON,
   parameter logic [HI_W+LO_W-1:0] WIN_OFF  = DEF_WIN_OFF
)(
   input  logic                          phiA,
   input  logic                          RST_async_n,
   input  logic                          phiL_NCEN,
   input  logic                          line_sync,
   input  logic                          txt_mode,
   input  logic [NDEC*(HI_W+LO_W)-1:0]   dec_val,
   input  logic [NDEC-1:0]               dec_lo_only,
   input  logic [NDEC*2-1:0]             dec_mode,
   output logic [HI_W+LO_W-1:0]          cnt,
   output logic [NDEC-1:0]               dec,
   output logic                          tile_eot,
   output logic                          win_active,
   output logic                          mode_q
);

   localparam int unsigned CW = HI_W + LO_W;

   logic [CW-1:0]   r_cnt;
   logic            r_mode_q;
   logic            r_tile_eot;
   logic            r_win;

   logic [LO_W-1:0] w_lo;
   logic [HI_W-1:0] w_hi;
   logic [LO_W-1:0] w_px_last;
   logic            w_wrap;
   logic            w_carry;
   logic [CW-1:0]   w_cnt_nxt;
   logic [NDEC-1:0] w_hit;

   assign w_lo      = r_cnt[LO_W-1:0];
   assign w_hi      = r_cnt[CW-1:LO_W];
   assign w_px_last = r_mode_q ? LO_W'(TXT_PX - 1) : LO_W'(GFX_PX - 1);
   assign w_wrap    = (r_cnt == (r_mode_q ? WRAP_TXT : WRAP_GFX));

   // Sync beats wrap beats tile carry; lo values past the tile width just roll over without carry.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_carry   = 1'b0;
      if (line_sync) begin
         w_cnt_nxt = SYNC_LD;
      end else if (w_wrap) begin
         w_cnt_nxt = WRAP_LD;
      end else if (w_lo == w_px_last) begin
         w_cnt_nxt[CW-1:LO_W] = w_hi + 1'b1;
         w_cnt_nxt[LO_W-1:0]  = '0;
         w_carry              = 1'b1;
      end else begin
         w_cnt_nxt[LO_W-1:0]  = w_lo + 1'b1;
      end
   end

   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         r_cnt      <= '0;
         r_mode_q   <= 1'b0;
         r_tile_eot <= 1'b0;
         r_win      <= 1'b0;
      end else if (phiL_NCEN) begin
         r_cnt      <= w_cnt_nxt;
         r_tile_eot <= w_carry;
         if (line_sync) begin
            r_mode_q <= txt_mode;
            r_win    <= 1'b0;
         end else if (r_cnt == WIN_OFF) begin
            r_win    <= 1'b0;
         end else if (r_cnt == WIN_ON) begin
            r_win    <= 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < NDEC; gi++) begin : g_dec
      ika9958_tilecyc_dec #(
         .LO_W (LO_W),
         .CW   (CW)
      ) u_dec (
         .i_cnt     (r_cnt),
         .i_val     (dec_val[gi*CW +: CW]),
         .i_lo_only (dec_lo_only[gi]),
         .i_mode    (dec_mode[gi*2 +: 2]),
         .i_txt     (r_mode_q),
         .o_hit     (w_hit[gi])
      );
   end

`ifdef IKA9958_TILECYC_DECREG_EN
   logic [NDEC-1:0] r_dec;

   always_ff @(posedge phiA or negedge RST_async_n) begin
      if (!RST_async_n) begin
         r_dec <= '0;
      end else if (phiL_NCEN) begin
         r_dec <= w_hit;
      end
   end

   assign dec = r_dec;
`else
   assign dec = w_hit;
`endif

   assign cnt        = r_cnt;
   assign tile_eot   = r_tile_eot;
   assign win_active = r_win;
   assign mode_q     = r_mode_q;

endmodule

// File: tb/tb_ika9958_tilecyc_gen.sv
// Directed bench for ika9958_tilecyc_gen: gfx/text line sequencing, wrap,
// sync priority, window flag, decode table, clock-enable hold and async reset.
module tb_ika9958_tilecyc_gen;

`ifdef IKA9958_TILECYC_DECREG_EN
   localparam bit DREG = 1'b1;
`else
   localparam bit DREG = 1'b0;
`endif

   logic        phiA;
   logic        RST_async_n;
   logic        phiL_NCEN;
   logic        line_sync;
   logic        txt_mode;
   logic [71:0] dec_val;
   logic [7:0]  dec_lo_only;
   logic [15:0] dec_mode;
   logic [8:0]  cnt;
   logic [7:0]  dec;
   logic        tile_eot;
   logic        win_active;
   logic        mode_q;

   int n_tests = 0;
   int n_fail  = 0;
   int eots;
   int d0hits;

   ika9958_tilecyc_gen dut (
      .phiA        (phiA),
      .RST_async_n (RST_async_n),
      .phiL_NCEN   (phiL_NCEN),
      .line_sync   (line_sync),
      .txt_mode    (txt_mode),
      .dec_val     (dec_val),
      .dec_lo_only (dec_lo_only),
      .dec_mode    (dec_mode),
      .cnt         (cnt),
      .dec         (dec),
      .tile_eot    (tile_eot),
      .win_active  (win_active),
      .mode_q      (mode_q)
   );

   initial phiA = 1'b0;
   always #5 phiA = ~phiA;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge phiA);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_cnt(input int n, output int n_eot, output int n_d0);
      n_eot = 0;
      n_d0  = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (tile_eot)  n_eot++;
         if (dec[0])    n_d0++;
      end
   endtask

   initial begin
      RST_async_n = 1'b0;
      phiL_NCEN   = 1'b1;
      line_sync   = 1'b0;
      txt_mode    = 1'b0;
      // e0: lo==9 text only; e1: cnt==000 any; e2: cnt==12F gfx only; rest never
      dec_val     = '0;
      dec_val[8:0]   = 9'h009;
      dec_val[17:9]  = 9'h000;
      dec_val[26:18] = 9'h12F;
      dec_lo_only = 8'b0000_0001;
      dec_mode    = 16'hFFE1;

      #12;
      chk("rst_cnt",   cnt, 9'h000);
      chk("rst_mode",  mode_q, 1'b0);
      chk("rst_win",   win_active, 1'b0);
      chk("rst_eot",   tile_eot, 1'b0);
      chk("rst_dec",   dec, DREG ? 8'h00 : 8'h02);

      RST_async_n = 1'b1;
      step();
      chk("post_rst_cnt", cnt, 9'h001);

      // Graphics line
      line_sync = 1'b1; txt_mode = 1'b0;
      step();
      line_sync = 1'b0;
      chk("gsync_cnt",  cnt, 9'h1E3);
      chk("gsync_mode", mode_q, 1'b0);
      chk("gsync_eot",  tile_eot, 1'b0);
      run(12);
      chk("g_1EF_cnt", cnt, 9'h1EF);
      chk("g_1EF_eot", tile_eot, 1'b0);
      step();
      chk("g_carry_cnt", cnt, 9'h1F0);
      chk("g_carry_eot", tile_eot, 1'b1);
      step();
      chk("g_eot_pulse", tile_eot, 1'b0);
      run(14);
      step();
      chk("g_hiwrap_cnt", cnt, 9'h000);
      chk("g_hiwrap_eot", tile_eot, 1'b1);
      chk("g_win_pre",    win_active, 1'b0);
      chk("g_dec_000",    dec, DREG ? 8'h00 : 8'h02);
      step();
      chk("g_win_on",     win_active, 1'b1);
      chk("g_dec_001",    dec, DREG ? 8'h02 : 8'h00);
      run_cnt(302, eots, d0hits);
      chk("g_12F_cnt",  cnt, 9'h12F);
      chk("g_eots",     eots, 18);
      chk("g_d0_never", d0hits, 0);
      chk("g_dec_12F",  dec, DREG ? 8'h00 : 8'h04);
      step();
      chk("g_wrap_cnt", cnt, 9'h1D1);
      chk("g_wrap_eot", tile_eot, 1'b0);
      chk("g_dec_1D1",  dec, DREG ? 8'h04 : 8'h00);

      // Text line
      line_sync = 1'b1; txt_mode = 1'b1;
      step();
      line_sync = 1'b0;
      chk("tsync_cnt",  cnt, 9'h1E3);
      chk("tsync_mode", mode_q, 1'b1);
      chk("tsync_win",  win_active, 1'b0);
      run(8);
      chk("t_1EB_cnt", cnt, 9'h1EB);
      chk("t_1EB_eot", tile_eot, 1'b0);
      step();
      chk("t_carry_cnt", cnt, 9'h1F0);
      chk("t_carry_eot", tile_eot, 1'b1);
      run_cnt(12, eots, d0hits);
      chk("t_tile_cnt",  cnt, 9'h000);
      chk("t_tile_eots", eots, 1);
      chk("t_tile_d0",   d0hits, 1);
      txt_mode = 1'b0;
      step();
      chk("t_win_on", win_active, 1'b1);
      run_cnt(119, eots, d0hits);
      chk("t_0A0_cnt",  cnt, 9'h0A0);
      chk("t_0A0_eots", eots, 10);
      chk("t_0A0_d0",   d0hits, 10);
      chk("t_0A0_mode", mode_q, 1'b1);
      run(120);
      chk("t_140_cnt", cnt, 9'h140);
      chk("t_140_win", win_active, 1'b1);
      step();
      chk("t_win_off", win_active, 1'b0);
      run(42);
      chk("t_177_cnt", cnt, 9'h177);
      step();
      chk("t_wrap_cnt", cnt, 9'h1D1);
      chk("t_wrap_eot", tile_eot, 1'b0);

      // Mode flips only at sync; then sync on the last pixel of a tile
      line_sync = 1'b1;
      step();
      line_sync = 1'b0;
      chk("flip_mode", mode_q, 1'b0);
      run(12);
      chk("s_1EF_cnt", cnt, 9'h1EF);
      line_sync = 1'b1;
      step();
      line_sync = 1'b0;
      chk("s_prio_cnt", cnt, 9'h1E3);
      chk("s_prio_eot", tile_eot, 1'b0);

      // Window cleared by sync mid-window
      run(13);
      run(16);
      chk("w_000_cnt", cnt, 9'h000);
      step();
      chk("w_on", win_active, 1'b1);
      run(159);
      chk("w_0A0_cnt", cnt, 9'h0A0);
      chk("w_0A0_win", win_active, 1'b1);
      line_sync = 1'b1;
      step();
      line_sync = 1'b0;
      chk("w_sync_cnt", cnt, 9'h1E3);
      chk("w_sync_win", win_active, 1'b0);

      // Clock-enable hold
      phiL_NCEN = 1'b0;
      run(5);
      chk("cen_hold_cnt", cnt, 9'h1E3);
      chk("cen_hold_win", win_active, 1'b0);
      phiL_NCEN = 1'b1;
      step();
      chk("cen_resume", cnt, 9'h1E4);

      // Async reset mid-line
      #2 RST_async_n = 1'b0;
      #1;
      chk("arst_cnt",  cnt, 9'h000);
      chk("arst_eot",  tile_eot, 1'b0);
      #3 RST_async_n = 1'b1;
      step();
      chk("arst_resume", cnt, 9'h001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
